// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Definitions shared by the UART receiver and transmitter:
//   - uart_state_t : FSM state encodings (IDLE/START/DATA/STOP/CLEANUP)
//   - DATA_BITS    : data bits per frame
//   - STOP_LEVEL   : line level of a valid stop bit
//   - IDLE_LEVEL   : line level when no frame is in flight
//   - half_period  : mid-bit offset used to centre the start-bit sample
// -----------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        START   = 3'd1,
        DATA    = 3'd2,
        STOP    = 3'd3,
        CLEANUP = 3'd4
    } uart_state_t;

    localparam int   DATA_BITS  = 8;
    localparam logic STOP_LEVEL = 1'b1;
    localparam logic IDLE_LEVEL = 1'b1;

    // Cycles from the start-edge detect to the middle of the start bit,
    // given a bit period of clocks_per_bit+1 cycles.
    function automatic int half_period(input int clocks_per_bit);
        return clocks_per_bit / 2;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// -----------------------------------------------------------------------------
// sync_2ff
// Two-flop synchronizer for a single asynchronous input. Both flops reset to 1
// so an idle-high line does not produce a false low edge coming out of reset.
// Ports:
//   i_clock  : destination clock
//   i_reset  : synchronous, active-high reset
//   i_async  : asynchronous input
//   o_sync   : input resynchronised to i_clock (2-cycle latency)
// -----------------------------------------------------------------------------
module sync_2ff (
    input  logic i_clock,
    input  logic i_reset,
    input  logic i_async,
    output logic o_sync
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
        end
    end

    assign o_sync = r_sync;

endmodule

// File: rtl/uart_receiver.sv
// -----------------------------------------------------------------------------
// uart_receiver
// 8N1 UART receiver. The bit period is CLOCKS_PER_BIT+1 clocks; every bit is
// sampled once, near its middle, relative to the detected start edge.
// Ports:
//   clock            : system clock, all logic on posedge
//   reset            : synchronous, active-high reset
//   serial           : asynchronous RX line, idle high
//   rx_data_byte     : last correctly framed byte; holds between bytes
//   rx_valid         : one-cycle pulse, rx_data_byte is new on this cycle
//   rx_framing_error : one-cycle pulse, stop bit was sampled low
//   rx_busy          : high in every state except IDLE
//   rx_state_dbg     : current FSM state, for observation only
// Output handshake: there is no ready. rx_valid is a single-cycle strobe and
// the consumer must capture rx_data_byte in that cycle; rx_valid and
// rx_framing_error are never high together.
// -----------------------------------------------------------------------------
import uart_pkg::*;

module uart_receiver #(
    parameter int CLOCKS_PER_BIT = 87
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        serial,
    output logic [7:0]  rx_data_byte,
    output logic        rx_valid,
    output logic        rx_framing_error,
    output logic        rx_busy,
    output uart_state_t rx_state_dbg
);

    localparam int            CW        = $clog2(CLOCKS_PER_BIT + 1);
    localparam logic [CW-1:0] CNT_HALF  = CW'(half_period(CLOCKS_PER_BIT));
    localparam logic [CW-1:0] CNT_FULL  = CW'(CLOCKS_PER_BIT);
    localparam logic [2:0]    LAST_BIT  = 3'(DATA_BITS - 1);

    logic                w_s;
    uart_state_t         r_state;
    logic [CW-1:0]       r_count;
    logic [2:0]          r_index;
    logic [7:0]          r_shift;
    logic [7:0]          r_data_byte;
    logic                r_valid;
    logic                r_framing_error;
    logic                r_busy;

    sync_2ff u_sync_rx (
        .i_clock (clock),
        .i_reset (reset),
        .i_async (serial),
        .o_sync  (w_s)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state         <= IDLE;
            r_count         <= '0;
            r_index         <= '0;
            r_shift         <= '0;
            r_data_byte     <= '0;
            r_valid         <= 1'b0;
            r_framing_error <= 1'b0;
            r_busy          <= 1'b0;
        end else begin
            // Strobes are only set on the stop-bit sample, so they last one cycle.
            r_valid         <= 1'b0;
            r_framing_error <= 1'b0;

            case (r_state)
                IDLE: begin
                    r_count <= '0;
                    r_index <= '0;
                    if (w_s != IDLE_LEVEL) begin
                        r_state <= START;
                        r_busy  <= 1'b1;
                    end
                end

                START: begin
                    if (r_count == CNT_HALF) begin
                        r_count <= '0;
                        if (w_s == 1'b0) begin
                            r_state <= DATA;
                        end else begin
                            // Line went back high before mid start bit: a glitch.
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
                        end
                    end else begin
                        r_count <= r_count + CW'(1);
                    end
                end

                DATA: begin
                    if (r_count == CNT_FULL) begin
                        r_count          <= '0;
                        r_shift[r_index] <= w_s;
                        if (r_index == LAST_BIT) begin
                            r_index <= '0;
                            r_state <= STOP;
                        end else begin
                            r_index <= r_index + 3'd1;
                        end
                    end else begin
                        r_count <= r_count + CW'(1);
                    end
                end

                STOP: begin
                    if (r_count == CNT_FULL) begin
                        r_count <= '0;
                        r_state <= CLEANUP;
                        if (w_s == STOP_LEVEL) begin
                            r_data_byte <= r_shift;
                            r_valid     <= 1'b1;
                        end else begin
                            r_framing_error <= 1'b1;
                        end
                    end else begin
                        r_count <= r_count + CW'(1);
                    end
                end

                CLEANUP: begin
                    // Hold here while the line is low so a break or stuck-low
                    // line cannot look like a fresh start edge.
                    r_count <= '0;
                    if (w_s == IDLE_LEVEL) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                end

                default: begin
                    r_state <= IDLE;
                    r_count <= '0;
                    r_index <= '0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign rx_data_byte     = r_data_byte;
    assign rx_valid         = r_valid;
    assign rx_framing_error = r_framing_error;
    assign rx_busy          = r_busy;
    assign rx_state_dbg     = r_state;

endmodule

// File: tb/tb_uart_receiver.sv
// -----------------------------------------------------------------------------
// tb_uart_receiver
// Self-checking bench for uart_receiver with CLOCKS_PER_BIT=15 (16-clock bit).
// Each scenario task drives frames and pushes the expected outcome
// {framing_error, byte} into exp_q; a monitor pops and compares on every
// output pulse.
// -----------------------------------------------------------------------------
module tb_uart_receiver;
    import uart_pkg::*;

    localparam int CPB      = 15;
    localparam int BIT_CLKS = CPB + 1;
    localparam int H        = CPB / 2;

    logic        clock  = 1'b0;
    logic        reset  = 1'b1;
    logic        serial = 1'b1;
    logic [7:0]  rx_data_byte;
    logic        rx_valid;
    logic        rx_framing_error;
    logic        rx_busy;
    uart_state_t rx_state_dbg;

    int          n_checks  = 0;
    int          n_fail    = 0;
    int          valid_cnt = 0;
    int          err_cnt   = 0;
    longint      cyc       = 0;
    longint      valid_t[$];
    logic [8:0]  exp_q[$];
    logic [8:0]  mon_e;
    logic        prev_pulse = 1'b0;

    uart_receiver #(.CLOCKS_PER_BIT(CPB)) dut (
        .clock            (clock),
        .reset            (reset),
        .serial           (serial),
        .rx_data_byte     (rx_data_byte),
        .rx_valid         (rx_valid),
        .rx_framing_error (rx_framing_error),
        .rx_busy          (rx_busy),
        .rx_state_dbg     (rx_state_dbg)
    );

    // clock / reset
    always #5 clock = ~clock;

    // scoreboard monitor, sampling 1 time unit after each active edge
    always @(posedge clock) begin
        #1;
        cyc++;
        if (rx_valid || rx_framing_error) begin
            n_checks++;
            if (rx_valid && rx_framing_error) begin
                n_fail++;
                $display("FAIL exclusive: valid=%b framing_error=%b both high", rx_valid, rx_framing_error);
            end
            n_checks++;
            if (prev_pulse) begin
                n_fail++;
                $display("FAIL pulse_width: pulse high for more than one cycle at cycle %0d", cyc);
            end
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_pulse: valid=%b err=%b data=%02h, expected no pulse",
                         rx_valid, rx_framing_error, rx_data_byte);
            end else begin
                mon_e = exp_q.pop_front();
                if ({rx_framing_error, rx_data_byte} !== mon_e || rx_valid !== ~mon_e[8]) begin
                    n_fail++;
                    $display("FAIL frame: got err=%b valid=%b data=%02h, expected err=%b data=%02h",
                             rx_framing_error, rx_valid, rx_data_byte, mon_e[8], mon_e[7:0]);
                end
            end
            if (rx_valid) begin
                valid_cnt++;
                valid_t.push_back(cyc);
            end
            if (rx_framing_error) err_cnt++;
        end
        prev_pulse = rx_valid | rx_framing_error;
    end

    // driver tasks
    task automatic wait_clks(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic send_bit(input logic b);
        serial = b;
        wait_clks(BIT_CLKS);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(stop);
    endtask

    // scenarios
    task automatic test_reset();
        reset  = 1'b1;
        serial = 1'b1;
        wait_clks(5);
        n_checks++;
        if (rx_data_byte !== 8'h00 || rx_valid !== 1'b0 || rx_framing_error !== 1'b0 ||
            rx_busy !== 1'b0 || rx_state_dbg !== IDLE) begin
            n_fail++;
            $display("FAIL reset_state: data=%02h valid=%b err=%b busy=%b state=%0d, expected all 0/IDLE",
                     rx_data_byte, rx_valid, rx_framing_error, rx_busy, rx_state_dbg);
        end
        reset = 1'b0;
        wait_clks(BIT_CLKS);
    endtask

    task automatic test_single();
        int v0 = valid_cnt;
        int e0 = err_cnt;
        exp_q.push_back({1'b0, 8'hA5});
        send_frame(8'hA5, 1'b1);
        wait_clks(BIT_CLKS);
        n_checks++;
        if (valid_cnt - v0 !== 1 || err_cnt !== e0) begin
            n_fail++;
            $display("FAIL single_counts: valid pulses=%0d err pulses=%0d, expected 1 and 0",
                     valid_cnt - v0, err_cnt - e0);
        end
        n_checks++;
        if (rx_busy !== 1'b0 || rx_data_byte !== 8'hA5) begin
            n_fail++;
            $display("FAIL single_idle: busy=%b data=%02h, expected 0 and a5", rx_busy, rx_data_byte);
        end
    endtask

    task automatic test_glitch();
        int v0 = valid_cnt;
        int e0 = err_cnt;
        int k  = 0;
        serial = 1'b0;
        wait_clks(4);
        serial = 1'b1;
        n_checks++;
        if (rx_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL glitch_detect: busy=%b, expected 1 after low edge", rx_busy);
        end
        while (rx_busy === 1'b1 && k <= H + 3) begin
            wait_clks(1);
            k++;
        end
        n_checks++;
        if (rx_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL glitch_busy: busy=%b after %0d cycles, expected 0 within %0d", rx_busy, k, H + 3);
        end
        wait_clks(3 * BIT_CLKS);
        n_checks++;
        if (valid_cnt !== v0 || err_cnt !== e0) begin
            n_fail++;
            $display("FAIL glitch_pulses: valid=%0d err=%0d new pulses, expected 0 and 0",
                     valid_cnt - v0, err_cnt - e0);
        end
    endtask

    task automatic test_framing();
        int v0 = valid_cnt;
        int e0 = err_cnt;
        logic [7:0] d = 8'h3C;
        exp_q.push_back({1'b1, 8'hA5});
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        serial = 1'b0;
        wait_clks(BIT_CLKS + 40);
        n_checks++;
        if (err_cnt - e0 !== 1 || valid_cnt !== v0) begin
            n_fail++;
            $display("FAIL framing_counts: err pulses=%0d valid pulses=%0d, expected 1 and 0",
                     err_cnt - e0, valid_cnt - v0);
        end
        n_checks++;
        if (rx_data_byte !== 8'hA5) begin
            n_fail++;
            $display("FAIL framing_hold: data=%02h, expected a5", rx_data_byte);
        end
        n_checks++;
        if (rx_busy !== 1'b1 || rx_state_dbg !== CLEANUP) begin
            n_fail++;
            $display("FAIL framing_stuck: busy=%b state=%0d, expected 1 and CLEANUP", rx_busy, rx_state_dbg);
        end
        serial = 1'b1;
        wait_clks(BIT_CLKS);
        n_checks++;
        if (rx_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL framing_release: busy=%b, expected 0 after line high", rx_busy);
        end
        exp_q.push_back({1'b0, 8'h5A});
        send_frame(8'h5A, 1'b1);
        wait_clks(BIT_CLKS);
        n_checks++;
        if (rx_data_byte !== 8'h5A || valid_cnt - v0 !== 1) begin
            n_fail++;
            $display("FAIL framing_recover: data=%02h valid pulses=%0d, expected 5a and 1",
                     rx_data_byte, valid_cnt - v0);
        end
    endtask

    task automatic test_back_to_back();
        int v0 = valid_cnt;
        exp_q.push_back({1'b0, 8'h00});
        exp_q.push_back({1'b0, 8'hFF});
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        wait_clks(BIT_CLKS);
        n_checks++;
        if (valid_cnt - v0 !== 2) begin
            n_fail++;
            $display("FAIL b2b_count: valid pulses=%0d, expected 2", valid_cnt - v0);
        end else begin
            n_checks++;
            if (valid_t[$] - valid_t[$-1] !== longint'(10 * BIT_CLKS)) begin
                n_fail++;
                $display("FAIL b2b_spacing: %0d cycles, expected %0d",
                         valid_t[$] - valid_t[$-1], 10 * BIT_CLKS);
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        int v0 = valid_cnt;
        int e0 = err_cnt;
        logic [7:0] d = 8'h81;
        send_bit(1'b0);
        for (int i = 0; i < 3; i++) send_bit(d[i]);
        serial = d[3];
        wait_clks(BIT_CLKS / 2);
        reset = 1'b1;
        @(posedge clock);
        #1;
        n_checks++;
        if (rx_data_byte !== 8'h00 || rx_valid !== 1'b0 || rx_framing_error !== 1'b0 ||
            rx_busy !== 1'b0 || rx_state_dbg !== IDLE) begin
            n_fail++;
            $display("FAIL reset_mid: data=%02h valid=%b err=%b busy=%b state=%0d, expected all 0/IDLE",
                     rx_data_byte, rx_valid, rx_framing_error, rx_busy, rx_state_dbg);
        end
        @(negedge clock);
        serial = 1'b1;
        reset  = 1'b0;
        wait_clks(2 * BIT_CLKS);
        n_checks++;
        if (valid_cnt !== v0 || err_cnt !== e0 || rx_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_quiet: valid=%0d err=%0d busy=%b, expected 0 0 0",
                     valid_cnt - v0, err_cnt - e0, rx_busy);
        end
        exp_q.push_back({1'b0, 8'h7E});
        send_frame(8'h7E, 1'b1);
        wait_clks(BIT_CLKS);
        n_checks++;
        if (rx_data_byte !== 8'h7E || valid_cnt - v0 !== 1) begin
            n_fail++;
            $display("FAIL reset_mid_next: data=%02h valid pulses=%0d, expected 7e and 1",
                     rx_data_byte, valid_cnt - v0);
        end
    endtask

    task automatic test_loopback();
        int v0 = valid_cnt;
        int e0 = err_cnt;
        for (int b = 0; b < 256; b++) begin
            exp_q.push_back({1'b0, 8'(b)});
            send_frame(8'(b), 1'b1);
            wait_clks($urandom_range(0, 20));
        end
        wait_clks(BIT_CLKS);
        n_checks++;
        if (valid_cnt - v0 !== 256 || err_cnt !== e0) begin
            n_fail++;
            $display("FAIL loopback_counts: valid=%0d err=%0d, expected 256 and 0",
                     valid_cnt - v0, err_cnt - e0);
        end
    endtask

    initial begin
        @(negedge clock);
        test_reset();
        test_single();
        test_glitch();
        test_framing();
        test_back_to_back();
        test_reset_mid_frame();
        test_loopback();
        wait_clks(3 * BIT_CLKS);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d expected pulses never seen, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
